// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared widths, defaults and control-state encoding for the VGA timing delay line
package vga_timing_pkg;
  localparam int HW_DEF = 11;
  localparam int VW_DEF = 11;
  localparam int RGB_W_DEF = 12;
  localparam logic SYNC_IDLE_DEF = 1'b0;
  typedef enum logic [1:0] {RUN, PENDING, FLUSH} state_t;
  function automatic int timing_w(input int hw, input int vw);
    return 4 + hw + vw;
  endfunction
  localparam int TIMING_W = timing_w(HW_DEF, VW_DEF);
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: WIDTH x DEPTH shift register with synchronous clear and runtime tap select
module sync_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int TW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             pclk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic [TW-1:0]    tap,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sr [DEPTH];
  always_ff @(posedge pclk)
    if (clr) sr <= '{default: '0};
    else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[tap];
endmodule

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: runtime-selectable delay of the VGA timing bundle, switched only at frame starts
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int MAX_DELAY = 8,
  parameter int DEFAULT_DELAY = 3,
  parameter int RGB_DELAY = 1,
  parameter int HW = HW_DEF,
  parameter int VW = VW_DEF,
  parameter int RGB_W = RGB_W_DEF,
  parameter int RGB_MASK = 1,
  parameter logic SYNC_IDLE = SYNC_IDLE_DEF,
  localparam int DW = $clog2(MAX_DELAY + 1)
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vs_in,
  input  logic             hs_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic [HW-1:0]    hcount_in,
  input  logic [VW-1:0]    vcount_in,
  input  logic [RGB_W-1:0] rgb_in,
  input  logic [DW-1:0]    delay_sel,
  input  logic             delay_load,
  output logic             vs_out,
  output logic             hs_out,
  output logic             hblnk,
  output logic             vblnk,
  output logic [HW-1:0]    hcount,
  output logic [VW-1:0]    vcount,
  output logic [RGB_W-1:0] rgb_out,
  output logic [DW-1:0]    cur_delay,
  output logic             locked
);
  localparam int BW = timing_w(HW, VW);
  localparam int TAPW = $clog2(MAX_DELAY);
  localparam int RTW = RGB_DELAY > 1 ? $clog2(RGB_DELAY) : 1;
  state_t state, state_n;
  logic [DW-1:0] cur_n, cnt, cnt_n, pend, pend_n, sel_c;
  logic pflag, pflag_n, vs_d, frame_edge, masked;
  logic [TAPW-1:0] tap;
  logic [BW-1:0] tq;
  logic [RGB_W-1:0] rgb_q;
  logic vs_t, hs_t, hb_t, vb_t;
  logic [HW-1:0] hc_t;
  logic [VW-1:0] vc_t;
  assign sel_c = delay_sel == '0 ? DW'(1) : (delay_sel > DW'(MAX_DELAY) ? DW'(MAX_DELAY) : delay_sel);
  assign frame_edge = vs_in & ~vs_d;
  always_comb begin
    state_n = state;
    cur_n = cur_delay;
    cnt_n = cnt;
    pend_n = pend;
    pflag_n = pflag;
    case (state)
      RUN: if (delay_load && sel_c != cur_delay) begin
        pend_n = sel_c;
        state_n = PENDING;
      end
      PENDING: begin
        pend_n = delay_load ? sel_c : pend;
        if (delay_load && sel_c == cur_delay) state_n = RUN;
        else if (frame_edge) begin
          cur_n = pend_n;
          cnt_n = pend_n;
          state_n = FLUSH;
        end
      end
      FLUSH: begin
        if (delay_load) begin
          pend_n = sel_c;
          pflag_n = sel_c != cur_delay;
        end
        cnt_n = cnt - DW'(1);
        if (cnt == DW'(1)) begin
          state_n = pflag_n ? PENDING : RUN;
          pflag_n = 1'b0;
        end
      end
      default: state_n = FLUSH;
    endcase
  end
  always_ff @(posedge pclk)
    if (rst) begin
      state <= FLUSH;
      cur_delay <= DW'(DEFAULT_DELAY);
      cnt <= DW'(DEFAULT_DELAY);
      pend <= DW'(DEFAULT_DELAY);
      pflag <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      state <= state_n;
      cur_delay <= cur_n;
      cnt <= cnt_n;
      pend <= pend_n;
      pflag <= pflag_n;
      vs_d <= vs_in;
    end
  assign tap = TAPW'(cur_delay - DW'(1));
  sync_delay_line #(.WIDTH(BW), .DEPTH(MAX_DELAY)) u_timing (
    .pclk(pclk),
    .clr (rst),
    .d   ({vs_in, hs_in, hblnk_in, vblnk_in, hcount_in, vcount_in}),
    .tap (tap),
    .q   (tq)
  );
  sync_delay_line #(.WIDTH(RGB_W), .DEPTH(RGB_DELAY)) u_rgb (
    .pclk(pclk),
    .clr (rst),
    .d   (rgb_in),
    .tap (RTW'(RGB_DELAY - 1)),
    .q   (rgb_q)
  );
  assign {vs_t, hs_t, hb_t, vb_t, hc_t, vc_t} = tq;
  assign masked = state == FLUSH;
  assign locked = ~masked;
  assign vs_out = masked ? SYNC_IDLE : vs_t;
  assign hs_out = masked ? SYNC_IDLE : hs_t;
  assign hblnk = masked | hb_t;
  assign vblnk = masked | vb_t;
  assign hcount = masked ? '0 : hc_t;
  assign vcount = masked ? '0 : vc_t;
  assign rgb_out = (masked || (RGB_MASK != 0 && (hblnk || vblnk))) ? '0 : rgb_q;
endmodule
